// File: rtl/fsm_escribir_rtc_mes_if.sv
// Signal bundle between the RAM->RTC month write FSM and the top-level bus mux.
// The master side is the FSM; the slave side is the top level that owns the RAM and the tristate.
interface fsm_escribir_rtc_mes_if;
  logic       do_it_escribir_mes;
  logic [7:0] dato_ram;
  logic       a_d;
  logic       cs;
  logic       rd;
  logic       wr;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       ram_to_rtc;
  logic       dir_ram_mes;
  logic       r_ram_enable;
  logic       done;

  modport master (
    input  do_it_escribir_mes, dato_ram,
    output a_d, cs, rd, wr, bus_out, bus_oe, ram_to_rtc, dir_ram_mes, r_ram_enable, done
  );

  modport slave (
    output do_it_escribir_mes, dato_ram,
    input  a_d, cs, rd, wr, bus_out, bus_oe, ram_to_rtc, dir_ram_mes, r_ram_enable, done
  );
endinterface

// File: rtl/fsm_escribir_rtc_mes.sv
// Copies the RAM month byte into the RTC month register: address cycle, RAM fetch, data cycle.
// Outputs are registered from the next-state decode, so they change together with the state.
//
// state       | meaning
// IDLE        | bus released, waiting for do_it_escribir_mes
// ADDR_SETUP  | cs low, ADDR_MES on the bus, wr high
// ADDR_STROBE | address strobe, wr low
// ADDR_HOLD   | wr high, address still driven
// GAP         | cs high, bus released, RAM month read; dato_ram latched on the last cycle
// DATA_SETUP  | cs low, latched month on the bus, wr high
// DATA_STROBE | data strobe, wr low
// DATA_HOLD   | wr high, data still driven
// DONE        | one-cycle done pulse, bus idle
module fsm_escribir_rtc_mes #(
  parameter logic [7:0] ADDR_MES = 8'h05,
  parameter int         T_SETUP  = 2,
  parameter int         T_STROBE = 4,
  parameter int         T_HOLD   = 2,
  parameter int         T_GAP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fsm_escribir_rtc_mes_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    GAP,
    DATA_SETUP,
    DATA_STROBE,
    DATA_HOLD,
    DONE
  } state_t;

  typedef struct packed {
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       ram_to_rtc;
    logic       dir_ram_mes;
    logic       r_ram_enable;
    logic       done;
  } out_t;

  localparam out_t OUT_IDLE = '{
    a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, bus_out: 8'h00, bus_oe: 1'b0,
    ram_to_rtc: 1'b0, dir_ram_mes: 1'b0, r_ram_enable: 1'b0, done: 1'b0
  };

  localparam logic [5:0] SETUP_LAST  = 6'(T_SETUP - 1);
  localparam logic [5:0] STROBE_LAST = 6'(T_STROBE - 1);
  localparam logic [5:0] HOLD_LAST   = 6'(T_HOLD - 1);
  localparam logic [5:0] GAP_LAST    = 6'(T_GAP - 1);

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [7:0] latch, latch_nxt;
  out_t       outs;

  function automatic out_t decode(input state_t s, input logic [7:0] d);
    out_t o;
    o = OUT_IDLE;
    o.ram_to_rtc = (s != IDLE);
    case (s)
      ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
        o.a_d     = 1'b0;
        o.cs      = 1'b0;
        o.bus_oe  = 1'b1;
        o.bus_out = ADDR_MES;
        o.wr      = (s != ADDR_STROBE);
      end
      GAP: begin
        o.dir_ram_mes  = 1'b1;
        o.r_ram_enable = 1'b1;
      end
      DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
        o.cs      = 1'b0;
        o.bus_oe  = 1'b1;
        o.bus_out = d;
        o.wr      = (s != DATA_STROBE);
      end
      DONE: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (bus.do_it_escribir_mes) state_nxt = ADDR_SETUP;
      ADDR_SETUP:  if (cnt == SETUP_LAST)      state_nxt = ADDR_STROBE;
      ADDR_STROBE: if (cnt == STROBE_LAST)     state_nxt = ADDR_HOLD;
      ADDR_HOLD:   if (cnt == HOLD_LAST)       state_nxt = GAP;
      GAP:         if (cnt == GAP_LAST)        state_nxt = DATA_SETUP;
      DATA_SETUP:  if (cnt == SETUP_LAST)      state_nxt = DATA_STROBE;
      DATA_STROBE: if (cnt == STROBE_LAST)     state_nxt = DATA_HOLD;
      DATA_HOLD:   if (cnt == HOLD_LAST)       state_nxt = DONE;
      DONE:                                    state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase

    // Counter is pinned at zero while idle so a fresh start always begins at 0.
    if (state_nxt != state || state == IDLE) cnt_nxt = 6'd0;
    else                                     cnt_nxt = cnt + 6'd1;

    // RAM data is valid by the last gap cycle (enable has been high since the first).
    if (state == GAP && cnt == GAP_LAST) latch_nxt = bus.dato_ram;
    else                                 latch_nxt = latch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
      latch <= 8'h00;
      outs  <= OUT_IDLE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      latch <= latch_nxt;
      outs  <= decode(state_nxt, latch_nxt);
    end
  end

  assign bus.a_d          = outs.a_d;
  assign bus.cs           = outs.cs;
  assign bus.rd           = outs.rd;
  assign bus.wr           = outs.wr;
  assign bus.bus_out      = outs.bus_out;
  assign bus.bus_oe       = outs.bus_oe;
  assign bus.ram_to_rtc   = outs.ram_to_rtc;
  assign bus.dir_ram_mes  = outs.dir_ram_mes;
  assign bus.r_ram_enable = outs.r_ram_enable;
  assign bus.done         = outs.done;

endmodule

// File: tb/tb_fsm_escribir_rtc_mes.sv
// Bench for the RAM->RTC month write FSM: per-cycle expected bus tables built from the
// documented cycle map, fed through a scoreboard queue, plus reset and back-to-back sequences.
module tb_fsm_escribir_rtc_mes;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsm_escribir_rtc_mes_if bus ();

  fsm_escribir_rtc_mes dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       bus_oe;
    logic       ram_to_rtc;
    logic       dir_ram_mes;
    logic       r_ram_enable;
    logic       done;
    logic [7:0] bus_out;
  } obs_t;

  typedef struct {
    logic       start;
    logic [7:0] dato;
    obs_t       exp;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;
  obs_t sb_q[$];
  vec_t tbl[64];

  function automatic obs_t idle_obs();
    obs_t o;
    o = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, bus_oe: 1'b0, ram_to_rtc: 1'b0,
          dir_ram_mes: 1'b0, r_ram_enable: 1'b0, done: 1'b0, bus_out: 8'h00};
    return o;
  endfunction

  // Expected outputs in cycle c after the start edge; a transaction occupies cycles 1..21,
  // cycle 22 is the IDLE separator, and n_tx back-to-back transactions repeat every 22 cycles.
  function automatic obs_t expect_cycle(input int c, input int n_tx, input logic [7:0] d);
    obs_t o;
    int   r;
    o = idle_obs();
    if (c < 1 || c > 22 * n_tx) return o;
    r = ((c - 1) % 22) + 1;
    if (r == 22) return o;
    o.ram_to_rtc = 1'b1;
    if (r <= 8) begin
      o.a_d = 1'b0; o.cs = 1'b0; o.bus_oe = 1'b1; o.bus_out = 8'h05;
      o.wr = !(r >= 3 && r <= 6);
    end else if (r <= 12) begin
      o.dir_ram_mes = 1'b1; o.r_ram_enable = 1'b1;
    end else if (r <= 20) begin
      o.cs = 1'b0; o.bus_oe = 1'b1; o.bus_out = d;
      o.wr = !(r >= 15 && r <= 18);
    end else begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{a_d: bus.a_d, cs: bus.cs, rd: bus.rd, wr: bus.wr, bus_oe: bus.bus_oe,
          ram_to_rtc: bus.ram_to_rtc, dir_ram_mes: bus.dir_ram_mes,
          r_ram_enable: bus.r_ram_enable, done: bus.done, bus_out: bus.bus_out};
    return o;
  endfunction

  // bus_out is only meaningful while driven, unless strict (reset value check).
  task automatic check_obs(input string name, input obs_t exp, input bit strict);
    obs_t act;
    act = sample();
    if (!strict && !exp.bus_oe) act.bus_out = exp.bus_out;
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {a_d cs rd wr oe busy dir ren done bus}=%b_%h required %b_%h",
               name, act[16:8], act[7:0], exp[16:8], exp[7:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Called just after a negedge: drive, push expectation, then pop and compare one cycle later.
  task automatic drive_vec(input string name, input vec_t v);
    obs_t exp;
    bus.do_it_escribir_mes = v.start;
    bus.dato_ram           = v.dato;
    sb_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    exp = sb_q.pop_front();
    check_obs(name, exp, 1'b0);
    if (bus.done) done_count++;
  endtask

  task automatic run_table(input string name, input int n);
    done_count = 0;
    for (int k = 0; k < n; k++) drive_vec($sformatf("%s_c%0d", name, k + 1), tbl[k]);
    bus.do_it_escribir_mes = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.do_it_escribir_mes = 1'b0;
    bus.dato_ram = 8'h00;
    #3;
    check_obs("reset_asserted", idle_obs(), 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_obs("after_reset", idle_obs(), 1'b1);
    @(negedge clk);
    check_obs("idle_no_start", idle_obs(), 1'b1);

    // Single transaction, month 0x09.
    for (int k = 0; k < 23; k++)
      tbl[k] = '{start: (k == 0), dato: 8'h09, exp: expect_cycle(k + 1, 1, 8'h09)};
    run_table("s2", 23);
    check_int("s2_done_count", done_count, 1);

    // RAM data changes after capture: bus keeps the latched 0x09.
    for (int k = 0; k < 23; k++)
      tbl[k] = '{start: (k == 0), dato: (k >= 14) ? 8'h12 : 8'h09,
                 exp: expect_cycle(k + 1, 1, 8'h09)};
    run_table("s3", 23);

    // Start pulses while busy are ignored.
    for (int k = 0; k < 30; k++)
      tbl[k] = '{start: (k == 0 || k == 5 || k == 17), dato: 8'h3C,
                 exp: expect_cycle(k + 1, 1, 8'h3C)};
    run_table("s4", 30);
    check_int("s4_done_count", done_count, 1);

    // Reset in the middle of the data strobe.
    for (int k = 0; k < 15; k++)
      tbl[k] = '{start: (k == 0), dato: 8'h5A, exp: expect_cycle(k + 1, 1, 8'h5A)};
    run_table("s5_pre", 15);
    @(posedge clk);
    #2;
    check_obs("s5_strobe_before_reset", expect_cycle(16, 1, 8'h5A), 1'b0);
    reset = 1'b1;
    #1;
    check_obs("s5_reset_immediate", idle_obs(), 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_int("s5_no_done", done_count, 0);
    done_count = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) done_count++;
    end
    check_obs("s5_idle_after_reset", idle_obs(), 1'b1);
    check_int("s5_no_late_done", done_count, 0);
    for (int k = 0; k < 23; k++)
      tbl[k] = '{start: (k == 0), dato: 8'hC7, exp: expect_cycle(k + 1, 1, 8'hC7)};
    run_table("s5_restart", 23);
    check_int("s5_restart_done_count", done_count, 1);

    // Start held high: two transactions one IDLE cycle apart, done at 21 and 43.
    for (int k = 0; k < 46; k++)
      tbl[k] = '{start: (k <= 43), dato: 8'hA5, exp: expect_cycle(k + 1, 2, 8'hA5)};
    run_table("s6", 46);
    check_int("s6_done_count", done_count, 2);

    check_int("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
